xor_prefix_decoder: RTL and testbench

- Bit-serial, handshaked decoder for the XOR-differenced code used in the divider datapath. The encoder rule is r[0]=q[0] and r[i]=q[i]^q[i-1].
- Recovers the original word by prefix-XOR: out[0]=in[0], out[i]=out[i-1]^in[i]. Bit 0 is the leading bit.
- Sits between the encoded quotient/remainder path and downstream consumers. Processes one bit per clock to keep area minimal.

---
 rtl/xor_codec_pkg.sv | 28 ++
 rtl/xor_prefix_decoder.sv | 87 ++++++++
 tb/tb_xor_prefix_decoder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_codec_pkg.sv
// Shared definitions for the XOR-differenced quotient code: FSM states,
// default width, and a combinational prefix-XOR golden model.
package xor_codec_pkg;

    localparam int XOR_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Decodes the low w bits of word; bits at and above w are returned as 0.
    function automatic logic [31:0] xor_prefix(input logic [31:0] word, input int w);
        logic [31:0] r;
        logic        acc;
        r   = '0;
        acc = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                acc  = acc ^ word[i];
                r[i] = acc;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/xor_prefix_decoder.sv
// Bit-serial prefix-XOR decoder: one input bit per clock, with a
// valid/ready handshake on both sides. Bit 0 is processed first.
module xor_prefix_decoder
    import xor_codec_pkg::*;
#(
    parameter int W = XOR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int            IW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  sreg_q, sreg_d;
    logic [W-1:0]  out_q, out_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          acc_q, acc_d;
    logic          acc_next;

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        out_d    = out_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        acc_next = acc_q ^ sreg_q[idx_q];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    acc_d   = 1'b0;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d        = acc_next;
                out_d[idx_q] = acc_next;
                // idx parks at the last bit; only a new accept rewinds it
                if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // All handshake outputs decode registered state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_xor_prefix_decoder.sv
// Directed and randomized checks of the prefix-XOR decoder at W=8, 2 and 32.
module tb_xor_prefix_decoder;
    import xor_codec_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        in_valid_s;
    logic        out_ready;
    int          sel;

    logic        iv8, iv2, iv32;
    logic        rdy8, rdy2, rdy32;
    logic        ov8, ov2, ov32;
    logic        bsy8, bsy2, bsy32;
    logic [7:0]  d8;
    logic [1:0]  d2;
    logic [31:0] d32;

    logic        s_ready, s_valid, s_busy;
    logic [31:0] s_data;

    int n_cmp = 0;
    int n_bad = 0;
    int xfer2 = 0;
    int xfer32 = 0;

    always #5 clk = ~clk;

    assign iv8  = in_valid_s && (sel == 8);
    assign iv2  = in_valid_s && (sel == 2);
    assign iv32 = in_valid_s && (sel == 32);

    xor_prefix_decoder #(.W(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .in_data(din[7:0]),
        .out_valid(ov8), .out_ready(out_ready), .out_data(d8), .busy(bsy8)
    );
    xor_prefix_decoder #(.W(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in_data(din[1:0]),
        .out_valid(ov2), .out_ready(out_ready), .out_data(d2), .busy(bsy2)
    );
    xor_prefix_decoder #(.W(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .in_data(din),
        .out_valid(ov32), .out_ready(out_ready), .out_data(d32), .busy(bsy32)
    );

    always_comb begin
        s_ready = rdy8;
        s_valid = ov8;
        s_busy  = bsy8;
        s_data  = {24'h0, d8};
        if (sel == 2) begin
            s_ready = rdy2;
            s_valid = ov2;
            s_busy  = bsy2;
            s_data  = {30'h0, d2};
        end else if (sel == 32) begin
            s_ready = rdy32;
            s_valid = ov32;
            s_busy  = bsy32;
            s_data  = d32;
        end
    end

    always @(posedge clk) begin
        if (!rst && ov2 && out_ready)  xfer2  <= xfer2 + 1;
        if (!rst && ov32 && out_ready) xfer32 <= xfer32 + 1;
    end

    // Stimulus only: accept one word on the selected DUT, then report the
    // number of edges until out_valid and the word seen there.
    task automatic send_word(input logic [31:0] d, output int lat,
                             output logic [31:0] res, output bit ok);
        int n;
        ok  = 1'b0;
        lat = -1;
        res = '0;
        n   = 0;
        while (!s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) return;
        din = d;
        in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        din = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (s_valid) begin
                lat = i;
                res = s_data;
                ok  = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        sel = 8;
        rst = 1'b1;
        in_valid_s = 1'b0;
        out_ready = 1'b1;
        din = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (rdy8 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", rdy8); end
        n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", ov8); end
        n_cmp++; if (d8 !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", d8); end
        n_cmp++; if (bsy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bsy8); end
    endtask

    task automatic test_basic;
        logic [7:0]  vin  [4] = '{8'h01, 8'hFF, 8'h03, 8'h80};
        logic [7:0]  vexp [4] = '{8'hFF, 8'h55, 8'h01, 8'h80};
        int          lat;
        logic [31:0] res;
        bit          ok;
        sel = 8;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_word({24'h0, vin[k]}, lat, res, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout in=%h no out_valid", vin[k]); end
            n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL basic_latency in=%h got %0d want 8", vin[k], lat); end
            n_cmp++; if (res[7:0] !== vexp[k]) begin n_bad++; $display("FAIL basic_data in=%h got %h want %h", vin[k], res[7:0], vexp[k]); end
        end
        @(posedge clk); #1;
        n_cmp++; if (rdy8 !== 1'b1 || ov8 !== 1'b0) begin n_bad++; $display("FAIL basic_return_idle got rdy=%b ov=%b want 1/0", rdy8, ov8); end
    endtask

    task automatic test_backpressure;
        sel = 8;
        out_ready = 1'b0;
        din = 32'h01;
        in_valid_s = 1'b1;
        @(posedge clk); #1;
        din = 32'hAA;
        repeat (8) @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            n_cmp++; if (ov8 !== 1'b1 || d8 !== 8'hFF) begin n_bad++; $display("FAIL bp_hold cyc=%0d got ov=%b d=%h want 1/ff", c, ov8, d8); end
            n_cmp++; if (rdy8 !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", c, rdy8); end
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (ov8 !== 1'b0 || rdy8 !== 1'b1 || bsy8 !== 1'b0) begin n_bad++; $display("FAIL bp_release got ov=%b rdy=%b busy=%b want 0/1/0", ov8, rdy8, bsy8); end
        n_cmp++; if (d8 !== 8'hFF) begin n_bad++; $display("FAIL bp_data_hold got %h want ff", d8); end
        @(posedge clk); #1;
        n_cmp++; if (ov8 !== 1'b0 || bsy8 !== 1'b0) begin n_bad++; $display("FAIL bp_no_second got ov=%b busy=%b want 0/0", ov8, bsy8); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3] = '{8'h01, 8'h00, 8'hFF};
        logic [7:0] wexp  [3] = '{8'hFF, 8'h00, 8'h55};
        logic [7:0] outs  [3];
        int         acc_cyc [3];
        int         wi, no;
        bit         a, t;
        sel = 8;
        out_ready = 1'b1;
        wi = 0;
        no = 0;
        din = {24'h0, words[0]};
        in_valid_s = 1'b1;
        for (int c = 0; c < 60 && no < 3; c++) begin
            a = in_valid_s && s_ready;
            t = s_valid && out_ready;
            if (t) begin
                outs[no] = s_data[7:0];
                no++;
            end
            @(posedge clk); #1;
            if (a) begin
                acc_cyc[wi] = c;
                wi++;
                if (wi < 3) din = {24'h0, words[wi]};
                else in_valid_s = 1'b0;
            end
        end
        in_valid_s = 1'b0;
        n_cmp++; if (no !== 3 || wi !== 3) begin n_bad++; $display("FAIL b2b_count got out=%0d acc=%0d want 3/3", no, wi); end
        if (no == 3 && wi == 3) begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++; if (outs[k] !== wexp[k]) begin n_bad++; $display("FAIL b2b_data idx=%0d got %h want %h", k, outs[k], wexp[k]); end
            end
            for (int k = 1; k < 3; k++) begin
                n_cmp++; if (acc_cyc[k] - acc_cyc[k-1] !== 10) begin n_bad++; $display("FAIL b2b_spacing idx=%0d got %0d want 10", k, acc_cyc[k] - acc_cyc[k-1]); end
            end
        end
    endtask

    task automatic test_reset_mid_word;
        int          lat;
        logic [31:0] res;
        bit          ok;
        sel = 8;
        out_ready = 1'b1;
        din = 32'hFF;
        in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (rdy8 !== 1'b1 || bsy8 !== 1'b0) begin n_bad++; $display("FAIL midrst_idle got rdy=%b busy=%b want 1/0", rdy8, bsy8); end
        n_cmp++; if (ov8 !== 1'b0 || d8 !== 8'h00) begin n_bad++; $display("FAIL midrst_out got ov=%b d=%h want 0/00", ov8, d8); end
        send_word(32'h03, lat, res, ok);
        n_cmp++; if (!ok || lat !== 8 || res[7:0] !== 8'h01) begin n_bad++; $display("FAIL midrst_next got ok=%b lat=%0d d=%h want 1/8/01", ok, lat, res[7:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep(input int w);
        int          lat, x0, x1, lat_bad, dat_bad;
        logic [31:0] res, d;
        bit          ok;
        sel = w;
        out_ready = 1'b1;
        lat_bad = 0;
        dat_bad = 0;
        @(posedge clk); #1;
        x0 = (w == 2) ? xfer2 : xfer32;
        for (int k = 0; k < 200; k++) begin
            d = $urandom;
            send_word(d, lat, res, ok);
            n_cmp++;
            if (!ok || lat !== w) begin
                n_bad++;
                if (lat_bad < 3) $display("FAIL sweep_latency w=%0d word=%0d got %0d want %0d", w, k, lat, w);
                lat_bad++;
            end
            n_cmp++;
            if (res !== xor_prefix(d, w)) begin
                n_bad++;
                if (dat_bad < 3) $display("FAIL sweep_data w=%0d in=%h got %h want %h", w, d, res, xor_prefix(d, w));
                dat_bad++;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        x1 = (w == 2) ? xfer2 : xfer32;
        n_cmp++; if (x1 - x0 !== 200) begin n_bad++; $display("FAIL sweep_transfers w=%0d got %0d want 200", w, x1 - x0); end
        n_cmp++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin n_bad++; $display("FAIL sweep_idle w=%0d got ov=%b busy=%b want 0/0", w, s_valid, s_busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_word;
        test_sweep(2);
        test_sweep(32);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
